fp_barrel_shift_pipe: RTL
=========================

Name: fp_barrel_shift_pipe

Overview:
- Parametrised, pipelined barrel shifter for the FP datapath (DIV/MUL/ADD mantissa alignment and normalisation).
- Generalises the fixed 24-bit combinational left shifter to:
  - configurable width;
  - four modes: logical left, logical right, arithmetic right, normalise-left;
  - an IEEE754 sticky output;
  - one register per log2 shift stage, with a valid/ready handshake and backpressure.

Parameters:
- WIDTH, 24: data width in bits (mantissa plus hidden bit). Legal range 2..64.
- SHW, 5: shift-amount width. Must satisfy 2**SHW >= WIDTH.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: asynchronous, active-high reset.
- in_valid, input, 1: input beat valid.
- in_ready, output, 1: block can accept a beat this cycle.
- in_data, input, WIDTH: operand.
- in_shamt, input, SHW: shift amount. Ignored in mode 11.
- in_mode, input, 2: 00 logical left, 01 logical right, 10 arithmetic right, 11 normalise-left.
- out_valid, output, 1: result valid.
- out_ready, input, 1: downstream accepts the result.
- out_data, output, WIDTH: shifted result.
- out_sticky, output, 1: OR of all 1-bits shifted out on the right. Always 0 for left modes.
- out_shamt, output, SHW+1: shift amount actually applied. Equals the leading-zero count in mode 11.
- out_zero, output, 1: in_data was all zeros.

Behaviour:
- Structure:
  - SHW stages, ordered MSB first: stage k shifts by 2**(SHW-1-k) when the corresponding amount bit is set.
  - Each stage has a register holding data, sticky, amount, mode, zero and valid.
- Latency: exactly SHW cycles from input acceptance to out_valid, when there is no stall.
- Handshake:
  - The pipeline uses a global stall. advance = out_ready OR NOT out_valid.
  - in_ready = advance.
  - An input beat is accepted when in_valid AND in_ready.
  - All stage registers load only when advance = 1. When advance = 0, every stage holds its contents.
  - Bubbles propagate as valid = 0 beats.
  - out_* stays stable while out_valid = 1 AND out_ready = 0.
  - Throughput is one beat per cycle. Order is preserved and no beat is dropped or duplicated.
- Reset:
  - Asynchronous reset clears all stage valid, data, sticky, amount and zero bits to 0.
  - After reset: out_valid = 0, out_data = 0, out_sticky = 0, out_shamt = 0, out_zero = 0.
  - Asserting rst mid-stream discards every in-flight beat. No partial output appears after deassertion.
  - in_ready = 1 during and after reset, because out_valid = 0.
- Mode 11 (normalise-left):
  - A combinational priority encoder in front of stage 0 computes lz, the leading-zero count of in_data, in the range 0..WIDTH.
  - The block performs a logical left shift by lz. out_shamt = lz.
  - If in_data = 0: out_data = 0, out_shamt = WIDTH, out_zero = 1.
- Modes 00, 01, 10: out_shamt = zero-extended in_shamt. out_zero reflects whether in_data == 0 in every mode.
- Over-range amount (in_shamt >= WIDTH, possible when 2**SHW > WIDTH):
  - Left modes: data = 0.
  - Logical right: data = 0.
  - Arithmetic right: data = all copies of in_data[WIDTH-1].
  - Sticky = OR of all in_data bits that are not retained.
  - The per-stage implementation must saturate naturally and must not wrap the amount modulo WIDTH.
- Sticky rules:
  - Each right-shifting stage ORs the bits it drops into the accumulated sticky.
  - For arithmetic right, only the original data bits dropped count; sign-fill bits never contribute.
- Widths: no internal width growth beyond WIDTH. out_shamt is SHW+1 bits so that it can hold WIDTH.

Test Plan:
- Mode 00, in_data=24'h000001, in_shamt=23 -> after 5 cycles: out_data=24'h800000, out_sticky=0, out_shamt=23.
- Mode 01, in_data=24'hABCDEF, in_shamt=4 -> out_data=24'h0ABCDE, out_sticky=1.
- Mode 10, in_data=24'h800010, in_shamt=4 -> out_data=24'hF80001, out_sticky=0.
- Mode 10, in_data=24'h800000, in_shamt=30 -> out_data=24'hFFFFFF, out_sticky=0.
- Mode 01, in_data=24'h000003, in_shamt=31 -> out_data=0, out_sticky=1.
- Mode 11, in_data=24'h00F000 -> out_data=24'hF00000, out_shamt=8, out_zero=0.
- Mode 11, in_data=0 -> out_data=0, out_shamt=24, out_zero=1.
- Stream 8 back-to-back beats of mixed modes, holding out_ready=0 for 3 cycles mid-stream:
  - in_ready=0 during the stall.
  - out_* stays stable during the stall.
  - All 8 results arrive in order, matching the reference model, with no loss or duplication.
- Assert rst for 1 cycle while 3 beats are in flight:
  - out_valid drops asynchronously to 0 and all outputs read 0.
  - No stale beat emerges afterwards.
  - The next accepted beat appears exactly 5 cycles later.

Source files
------------

// File: rtl/fp_barrel_shift_pipe_if.sv
// Handshake bundle for fp_barrel_shift_pipe.
//   master: upstream/downstream environment (drives in_* beat and out_ready)
//   slave : the shifter pipeline (drives in_ready and out_* result)
// Mode encoding on in_mode: 00 lsl, 01 lsr, 10 asr, 11 normalise-left.
interface fp_barrel_shift_pipe_if #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned SHW   = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_shamt;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_sticky;
  logic [SHW:0]     out_shamt;
  logic             out_zero;

  modport master (
    output in_valid, in_data, in_shamt, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_sticky, out_shamt, out_zero
  );

  modport slave (
    input  in_valid, in_data, in_shamt, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_sticky, out_shamt, out_zero
  );
endinterface

// File: rtl/fp_barrel_shift_pipe.sv
// Pipelined barrel shifter for FP mantissa alignment / normalisation.
// One register stage per shift-amount bit, MSB stage first. Global stall:
// every stage loads only when the output is free or being consumed.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset, clears all stages
//   bus  - fp_barrel_shift_pipe_if slave: in_* beat with valid/ready,
//          out_* result (data, sticky, applied amount, zero flag) with valid/ready
module fp_barrel_shift_pipe #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned SHW   = 5
) (
  input logic                  clk,
  input logic                  rst,
  fp_barrel_shift_pipe_if.slave bus
);

  localparam logic [1:0] ModeLsl  = 2'b00;
  localparam logic [1:0] ModeLsr  = 2'b01;
  localparam logic [1:0] ModeAsr  = 2'b10;
  localparam logic [1:0] ModeNorm = 2'b11;

  localparam logic [WIDTH-1:0] Ones = '1;

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] data;
    logic             sticky;
    logic [SHW:0]     amt;
    logic [1:0]       mode;
    logic             zero;
  } beat_t;

  logic     advance;
  logic [SHW:0] lz;
  beat_t    front;
  beat_t    stage_out [SHW];

  assign advance      = bus.out_ready | ~stage_out[SHW-1].valid;
  assign bus.in_ready = advance;

  // Leading-zero count; the highest set bit is the last one to write lz.
  always_comb begin
    lz = (SHW+1)'(WIDTH);
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (bus.in_data[i]) lz = (SHW+1)'(int'(WIDTH) - 1 - i);
    end
  end

  always_comb begin
    front        = '0;
    front.valid  = bus.in_valid;
    front.data   = bus.in_data;
    front.zero   = ~|bus.in_data;
    front.mode   = bus.in_mode;
    front.amt    = (bus.in_mode == ModeNorm) ? lz : {1'b0, bus.in_shamt};
  end

  for (genvar k = 0; k < int'(SHW); k++) begin : g_stage
    localparam int unsigned AmtBit = SHW - 1 - k;
    localparam int unsigned Sh     = 1 << AmtBit;

    beat_t        src;
    beat_t        stage_d;
    beat_t        stage_q;
    logic [SHW:0] acc;
    int unsigned  lim;
    logic [WIDTH-1:0] drop_mask;

    if (k == 0) begin : g_src_front
      assign src = front;
    end else begin : g_src_prev
      assign src = stage_out[k-1];
    end

    always_comb begin
      // acc: shift already applied by the earlier (larger) stages.
      acc = (src.amt >> (AmtBit + 1)) << (AmtBit + 1);
      // For asr, bits at or above WIDTH-1-acc are sign copies (the original MSB
      // and its fill); they are retained in spirit and must not feed sticky.
      if (src.mode == ModeAsr) begin
        lim = (int'(acc) >= int'(WIDTH) - 1) ? 0 : WIDTH - 1 - int'(acc);
      end else begin
        lim = WIDTH;
      end
      drop_mask = ~(Ones << Sh) & ~(Ones << lim);

      stage_d = src;
      if (src.amt[AmtBit]) begin
        unique case (src.mode)
          ModeLsr: begin
            stage_d.data   = src.data >> Sh;
            stage_d.sticky = src.sticky | (|(src.data & drop_mask));
          end
          ModeAsr: begin
            stage_d.data   = WIDTH'($signed(src.data) >>> Sh);
            stage_d.sticky = src.sticky | (|(src.data & drop_mask));
          end
          ModeLsl, ModeNorm: begin
            stage_d.data   = src.data << Sh;
          end
          default: stage_d = src;
        endcase
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        stage_q <= '0;
      end else if (advance) begin
        stage_q <= stage_d;
      end
    end

    assign stage_out[k] = stage_q;
  end

  assign bus.out_valid  = stage_out[SHW-1].valid;
  assign bus.out_data   = stage_out[SHW-1].data;
  assign bus.out_sticky = stage_out[SHW-1].sticky;
  assign bus.out_shamt  = stage_out[SHW-1].amt;
  assign bus.out_zero   = stage_out[SHW-1].zero;

endmodule
